// File: rtl/dff_posedge.sv
// ---------------------------------------------------------------------------
// dff_posedge
//
// Bank of WIDTH independent positive-edge D flip-flops sharing one clock and
// one pair of asynchronous active-low controls.
//
// Optional feature macro: DFF_POSEDGE_CE_EN
//   When defined, adds an active-high clock enable input 'ce' after 'd'.
//   When undefined, every rising clk edge captures d.
//
// Ports:
//   clk     in   1      rising-edge capture clock
//   clear   in   1      async active-low clear: q=0, qbar=1 (highest priority)
//   preset  in   1      async active-low set:   q=1, qbar=0 (below clear)
//   d       in   WIDTH  data captured on rising clk
//   ce      in   1      clock enable (only with DFF_POSEDGE_CE_EN)
//   q       out  WIDTH  stored value
//   qbar    out  WIDTH  bitwise complement of q
// ---------------------------------------------------------------------------
module dff_posedge #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic [WIDTH-1:0] d,
`ifdef DFF_POSEDGE_CE_EN
    input  logic             ce,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // Effective set request: preset only counts while clear is released.
    // Gating it with clear means releasing clear while preset is still low
    // produces a falling edge here, so the flop moves to 1 immediately
    // instead of staying at the cleared value.
    logic w_set_n;
    assign w_set_n = preset | ~clear;

    logic w_cap_en;
`ifdef DFF_POSEDGE_CE_EN
    assign w_cap_en = ce;
`else
    assign w_cap_en = 1'b1;
`endif

    logic [WIDTH-1:0] r_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or negedge clear or negedge w_set_n) begin
                if (!clear) begin
                    r_q[gi] <= 1'b0;
                end else if (!w_set_n) begin
                    r_q[gi] <= 1'b1;
                end else if (w_cap_en) begin
                    r_q[gi] <= d[gi];
                end
            end
        end
    endgenerate

    // qbar is derived from the same storage bit so the pair can never
    // disagree, including during forced states.
    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: tb/tb_dff_posedge.sv
// ---------------------------------------------------------------------------
// tb_dff_posedge
//
// Directed self-checking bench for dff_posedge with WIDTH=4. The clock is
// driven by hand so the asynchronous tests can run with no clock edge.
// With DFF_POSEDGE_CE_EN defined the clock-enable hold case is also covered.
// ---------------------------------------------------------------------------
module tb_dff_posedge;

    localparam int W = 4;

    logic         clk;
    logic         clear;
    logic         preset;
    logic [W-1:0] d;
    logic         ce;
    logic [W-1:0] q;
    logic [W-1:0] qbar;

    int n_checks;
    int n_errors;

    dff_posedge #(.WIDTH(W)) dut (
        .clk    (clk),
        .clear  (clear),
        .preset (preset),
        .d      (d),
`ifdef DFF_POSEDGE_CE_EN
        .ce     (ce),
`endif
        .q      (q),
        .qbar   (qbar)
    );

    task automatic check_val(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    // Check q and its complement in one go.
    task automatic check_q(input string tag, input logic [W-1:0] exp_q);
        check_val({tag, ".q"}, q, exp_q);
        check_val({tag, ".qbar"}, qbar, ~exp_q);
    endtask

    task automatic rise();
        #4 clk = 1'b1;
        #1;
    endtask

    task automatic fall();
        #4 clk = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk      = 1'b0;
        clear    = 1'b1;
        preset   = 1'b1;
        d        = 4'hF;
        ce       = 1'b1;
        #5;

        // Async clear with clk idle low
        clear = 1'b0;
        #1 check_q("async_clear", 4'h0);

        // Clear holds across clock edges and toggling d
        for (int i = 0; i < 5; i++) begin
            d = (i % 2 == 0) ? 4'hF : 4'h0;
            rise();
            check_q($sformatf("clear_hold%0d", i), 4'h0);
            fall();
        end

        // Release of clear does not capture
        d = 4'hF;
        clear = 1'b1;
        #1 check_q("clear_release", 4'h0);

        // Capture, falling edge ignored, next capture
        rise();
        check_q("cap_ones", 4'hF);
        d = 4'h0;
        fall();
        check_q("fall_no_change", 4'hF);
        rise();
        check_q("cap_zeros", 4'h0);
        fall();

        // Async preset between edges, release holds until next edge
        preset = 1'b0;
        #1 check_q("async_preset", 4'hF);
        d = 4'h0;
        preset = 1'b1;
        #1 check_q("preset_release", 4'hF);
        rise();
        check_q("post_preset_cap", 4'h0);
        fall();

        // Priority: both low -> clear wins; release clear -> preset takes over
        preset = 1'b0;
        clear  = 1'b0;
        #1 check_q("both_low", 4'h0);
        clear = 1'b1;
        #1 check_q("clear_rel_preset_low", 4'hF);
        preset = 1'b1;
        #1 check_q("preset_rel_after", 4'hF);

        // Edge during clear is ignored and not captured later
        clear = 1'b0;
        d = 4'hF;
        rise();
        check_q("edge_in_clear", 4'h0);
        fall();
        clear = 1'b1;
        #1 check_q("no_late_capture", 4'h0);

        // Mixed pattern capture
        d = 4'b1010;
        rise();
        check_q("cap_1010", 4'b1010);
        fall();

`ifdef DFF_POSEDGE_CE_EN
        ce = 1'b0;
        d  = 4'b0110;
        rise();
        check_q("ce_low_hold", 4'b1010);
        fall();
        ce = 1'b1;
        rise();
        check_q("ce_high_cap", 4'b0110);
        fall();
`else
        d = 4'b0110;
        rise();
        check_q("cap_0110", 4'b0110);
        fall();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
